bit_serializer: RTL

- Parallel-to-serial front end feeding the serial `din` input of the team's Mealy sequence detectors, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first by default.
- A one-word holding register lets back-to-back words stream with no idle bit between them, so patterns spanning word boundaries, such as ...1101, remain detectable.

---
 rtl/bit_serializer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the serial sequence detectors. It accepts
// WIDTH-bit words over a valid/ready handshake and shifts them out one bit
// per clock, MSB-first by default. A one-word holding register lets
// back-to-back words stream with no idle bit between them. This keeps
// patterns that span a word boundary visible to the downstream detector.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level driven on dout while no word is being shifted
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    upstream word valid
//   in_data     upstream word, held stable while in_valid && !in_ready
//   in_ready    a word can be accepted this cycle
//   dout        serial bit (registered)
//   dout_valid  dout carries a word bit this cycle (registered)
//   word_done   final bit of a word is on dout this cycle
//   busy        shifter or holding register occupied
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;

    logic               accept;
    logic [WIDTH-1:0]   shift_adv;

    // Ready drops during reset so nothing is accepted while the block is
    // being cleared.
    assign in_ready = !rst && !hold_valid_q;
    assign accept   = in_valid && in_ready;

    // The shifter always presents the bit currently on dout at its output
    // end. Advancing moves the next bit into that position.
    assign shift_adv = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    // NOTE: every signal written here gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                // Bypass load: hold is always empty in IDLE.
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = in_data;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    // Last bit leaving. The held word has priority. A new
                    // accept cannot coincide with it because in_ready is low.
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        cnt_d        = '0;
                    end else if (accept) begin
                        shift_d = in_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + 1'b1;
                    if (accept) begin
                        hold_d       = in_data;
                        hold_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // dout is registered, so it is taken from the next shifter contents.
        dout_valid_d = (state_d == SHIFT);
        if (state_d == SHIFT) begin
            dout_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end else begin
            dout_d = IDLE_BIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Other
    // processes then see pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign word_done  = dout_valid_q && (cnt_q == LAST_CNT);
    assign busy       = (state_q == SHIFT) || hold_valid_q;

endmodule
